// File: rtl/gf180mcu_fd_sc_mcu7t5v0__aoi221_rbank_pkg.sv
// Shared constants, the per-channel term record and the configuration check
// for the registered AOI221/OAI221 bank.
package gf180mcu_fd_sc_mcu7t5v0__aoi221_rbank_pkg;

  localparam logic MODE_AOI   = 1'b0;
  localparam logic MODE_OAI   = 1'b1;

  localparam int   STAGES_MIN = 1;
  localparam int   STAGES_MAX = 2;
  localparam int   CH_MAX     = 32;

  // One channel's worth of gate inputs; also the input-stage flop record.
  typedef struct packed {
    logic a1;
    logic a2;
    logic b1;
    logic b2;
    logic c;
  } term_t;

  // Legal channel count and pipeline depth.
  function automatic bit cfg_ok(input int ch, input int stages);
    return (ch >= 1) && (ch <= CH_MAX) &&
           (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__aoi221_cfg_slice.sv
// Single-channel combinational 2-2-1 gate: AOI221 or OAI221 under mode.
module gf180mcu_fd_sc_mcu7t5v0__aoi221_cfg_slice
  import gf180mcu_fd_sc_mcu7t5v0__aoi221_rbank_pkg::*;
(
  input  logic  mode,
  input  term_t t,
  output logic  zn
);

  logic aoi;
  logic oai;

  assign aoi = ~((t.a1 & t.a2) | (t.b1 & t.b2) | t.c);
  assign oai = ~((t.a1 | t.a2) & (t.b1 | t.b2) & t.c);

  // An unknown mode merges both results, so X only shows where they differ.
  assign zn  = (mode == MODE_OAI) ? oai : aoi;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__aoi221_rbank.sv
// Registered bank of CH AOI221/OAI221 channels with clock enable, optional
// input stage and a mux-scan chain threaded through the output register.
module gf180mcu_fd_sc_mcu7t5v0__aoi221_rbank
  import gf180mcu_fd_sc_mcu7t5v0__aoi221_rbank_pkg::*;
#(
  parameter int CH     = 4,
  parameter int STAGES = 1
) (
  input  logic          CLK,
  input  logic          RN,
  inout  wire           VDD,
  inout  wire           VSS,
  input  logic [CH-1:0] A1,
  input  logic [CH-1:0] A2,
  input  logic [CH-1:0] B1,
  input  logic [CH-1:0] B2,
  input  logic [CH-1:0] C,
  input  logic          MODE,
  input  logic          E,
  input  logic          SE,
  input  logic          SI,
  output logic [CH-1:0] ZN,
  output logic          SO
);

  if (!cfg_ok(CH, STAGES)) begin : g_cfg_err
    $fatal(1, "aoi221_rbank: illegal CH=%0d / STAGES=%0d", CH, STAGES);
  end

  // Rails carry no logic in the RTL view.
  wire unused_rails = VDD ^ VSS;

  term_t [CH-1:0] raw_t;
  term_t [CH-1:0] cur_t;
  logic           cur_mode;
  logic [CH-1:0]  f;
  logic [CH-1:0]  shift_d;

  for (genvar i = 0; i < CH; i++) begin : g_pack
    assign raw_t[i] = {A1[i], A2[i], B1[i], B2[i], C[i]};
  end

  if (STAGES == 2) begin : g_istage
    term_t [CH-1:0] in_q;
    logic           mode_q;

    // Input stage advances with the output register; frozen during scan.
    always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
        in_q   <= '0;
        mode_q <= 1'b0;
      end else begin
        in_q   <= SE ? in_q   : (E ? raw_t : in_q);
        mode_q <= SE ? mode_q : (E ? MODE  : mode_q);
      end
    end

    assign cur_t    = in_q;
    assign cur_mode = mode_q;
  end else begin : g_direct
    assign cur_t    = raw_t;
    assign cur_mode = MODE;
  end

  for (genvar i = 0; i < CH; i++) begin : g_slice
    gf180mcu_fd_sc_mcu7t5v0__aoi221_cfg_slice u_slice (
      .mode (cur_mode),
      .t    (cur_t[i]),
      .zn   (f[i])
    );
  end

  if (CH == 1) begin : g_scan1
    assign shift_d = SI;
  end else begin : g_scann
    assign shift_d = {ZN[CH-2:0], SI};
  end

  // Output register: scan shift wins over functional capture, else hold.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) ZN <= '0;
    else     ZN <= SE ? shift_d : (E ? f : ZN);
  end

  assign SO = ZN[CH-1];

endmodule
